// File: rtl/demux_chan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// demux_chan_sequencer_pkg
// Shared definitions for the demux channel sequencer: default channel count,
// select width and the sequencer state encoding.
// -----------------------------------------------------------------------------
package demux_chan_sequencer_pkg;

    localparam int NCH_DEF   = 8;
    localparam int SEL_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage : demux_chan_sequencer_pkg

// File: rtl/demux_chan_sequencer_lowest_set_idx.sv
// -----------------------------------------------------------------------------
// lowest_set_idx
// Combinational priority encoder: returns the index of the lowest set bit of
// i_vec and whether any bit is set at all.
//
// Ports:
//   i_vec  in   NCH    vector to search
//   o_idx  out  SEL_W  index of the lowest set bit (0 when i_vec is zero)
//   o_any  out  1      i_vec has at least one bit set
// -----------------------------------------------------------------------------
module lowest_set_idx
    import demux_chan_sequencer_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [NCH-1:0]   i_vec,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        o_idx = '0;
        o_any = 1'b0;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (i_vec[k]) begin
                o_idx = SEL_W'(k);
                o_any = 1'b1;
            end
        end
    end

endmodule : lowest_set_idx

// File: rtl/demux_chan_sequencer.sv
// -----------------------------------------------------------------------------
// demux_chan_sequencer
// Upstream feeder for the 1-to-8 demultiplexer. Accepts a data word and a
// channel-enable mask over valid/ready, then walks the enabled channels in
// ascending order, one per cycle, driving sel/din. Pulses frame_done after the
// last channel and then holds off new words for GAP_CYCLES idle cycles.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_data     in   NCH    word to distribute; bit k goes to channel k
//   in_mask     in   NCH    channel enables; bit k=1 visits channel k
//   in_valid    in   1      word/mask present
//   in_ready    out  1      block can accept a word (registered)
//   hold        in   1      downstream stall; freezes delivery in SHIFT
//   abort       in   1      synchronous frame abort, back to IDLE
//   sel         out  SEL_W  demux select
//   din         out  1      demux data bit
//   out_valid   out  1      current sel/din is a delivered channel
//   frame_done  out  1      one-cycle pulse after the last channel
//   busy        out  1      state is not IDLE
// -----------------------------------------------------------------------------
module demux_chan_sequencer
    import demux_chan_sequencer_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   in_data,
    input  logic [NCH-1:0]   in_mask,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    input  logic             abort,
    output logic [SEL_W-1:0] sel,
    output logic             din,
    output logic             out_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    state_t           r_state;
    logic [NCH-1:0]   r_data;
    logic [NCH-1:0]   r_mask;
    logic [SEL_W-1:0] r_sel;
    logic             r_din;
    logic             r_in_ready;
    logic             r_frame_done;
    logic [7:0]       r_gap_cnt;

    logic             w_accept;
    logic [NCH-1:0]   w_next_mask;
    logic [SEL_W-1:0] w_init_idx;
    logic             w_init_any;
    logic [SEL_W-1:0] w_next_idx;
    logic             w_next_any;
    state_t           w_end_state;
    logic             w_end_ready;

    assign w_accept    = (r_state == IDLE) && r_in_ready && in_valid;
    // Mask with the channel currently on sel removed; its lowest bit is the next channel.
    assign w_next_mask = r_mask & ~(NCH'(1) << r_sel);

    // With no gap configured a finished frame returns straight to IDLE, ready at once.
    always_comb begin
        w_end_state = GAP;
        w_end_ready = 1'b0;
        if (GAP_CYCLES == 0) begin
            w_end_state = IDLE;
            w_end_ready = 1'b1;
        end
    end

    lowest_set_idx #(.NCH(NCH), .SEL_W(SEL_W)) u_init_idx (
        .i_vec (in_mask),
        .o_idx (w_init_idx),
        .o_any (w_init_any)
    );

    lowest_set_idx #(.NCH(NCH), .SEL_W(SEL_W)) u_next_idx (
        .i_vec (w_next_mask),
        .o_idx (w_next_idx),
        .o_any (w_next_any)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data/mask are plain flops, not a memory, so clearing them on reset is cheap and keeps state deterministic.
            r_state      <= IDLE;
            r_data       <= '0;
            r_mask       <= '0;
            r_sel        <= '0;
            r_din        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (abort) begin
                // Abort wins over hold and over a word offered this cycle.
                r_state    <= IDLE;
                r_mask     <= '0;
                r_sel      <= '0;
                r_din      <= 1'b0;
                r_in_ready <= 1'b1;
                r_gap_cnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_in_ready <= 1'b0;
                            r_data     <= in_data;
                            r_mask     <= in_mask;
                            if (w_init_any) begin
                                r_state <= SHIFT;
                                r_sel   <= w_init_idx;
                                r_din   <= in_data[w_init_idx];
                            end else begin
                                // Empty frame: nothing to drive, just signal completion.
                                r_frame_done <= 1'b1;
                                r_state      <= w_end_state;
                                r_gap_cnt    <= GAP_LOAD;
                            end
                        end else begin
                            r_in_ready <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (!hold) begin
                            r_mask <= w_next_mask;
                            if (w_next_any) begin
                                r_sel <= w_next_idx;
                                r_din <= r_data[w_next_idx];
                            end else begin
                                r_sel        <= '0;
                                r_din        <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_state      <= w_end_state;
                                r_in_ready   <= w_end_ready;
                                r_gap_cnt    <= GAP_LOAD;
                            end
                        end
                    end
                    GAP: begin
                        // Counter started at GAP_CYCLES; leaving at 1 gives exactly GAP_CYCLES idle cycles.
                        if (r_gap_cnt <= 8'd1) begin
                            r_state    <= IDLE;
                            r_in_ready <= 1'b1;
                            r_gap_cnt  <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign sel        = r_sel;
    assign din        = r_din;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != IDLE);
    // Only combinational input-to-output path: a stall suppresses delivery in the same cycle.
    assign out_valid  = (r_state == SHIFT) && !hold;

endmodule : demux_chan_sequencer

// File: tb/tb_demux_chan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_chan_sequencer
// Directed bench for demux_chan_sequencer. Stimulus pushes the expected
// delivery / frame_done sequence into a queue; a monitor pops and compares on
// every cycle where the DUT presents out_valid or frame_done. Timing and
// state checks are made directly in the stimulus thread.
// -----------------------------------------------------------------------------
module tb_demux_chan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data;
    logic [7:0] in_mask;
    logic       in_valid;
    logic       in_ready;
    logic       hold;
    logic       abort;
    logic [2:0] sel;
    logic       din;
    logic       out_valid;
    logic       frame_done;
    logic       busy;

    always #5 clk = ~clk;

    demux_chan_sequencer #(.NCH(8), .SEL_W(3), .GAP_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hold       (hold),
        .abort      (abort),
        .sel        (sel),
        .din        (din),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct {
        logic       is_done;
        logic [2:0] sel;
        logic       din;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_dlv(input logic [2:0] s, input logic d);
        exp_t e;
        e.is_done = 1'b0;
        e.sel     = s;
        e.din     = d;
        q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.sel     = 3'd0;
        e.din     = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] data, input logic [7:0] mask);
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) push_dlv(3'(k), data[k]);
        end
        push_done();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    // Offer a word at a negedge where in_ready is high; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] data, input logic [7:0] mask);
        wait_ready();
        in_data  = data;
        in_mask  = mask;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (out_valid || frame_done)) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {30'd0, out_valid, frame_done}, 0);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.is_done) begin
                        check("sb_frame_done", {30'd0, frame_done, out_valid}, 32'h2);
                    end else begin
                        check("sb_valid", {30'd0, out_valid, frame_done}, 32'h2);
                        check("sb_sel", sel, mon_e.sel);
                        check("sb_din", din, mon_e.din);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data  = '0;
        in_mask  = '0;
        in_valid = 1'b0;
        hold     = 1'b0;
        abort    = 1'b0;
        rst_n    = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_sel", sel, 0);
        check("rst_din", din, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", in_ready, 0);
        @(negedge clk);
        check("ready_after_edge", in_ready, 1);

        // Full mask, A5: sel 0..7, din 1,0,1,0,0,1,0,1.
        push_frame(8'hA5, 8'hFF);
        send(8'hA5, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("full_ov", out_valid, 1);
            check("full_sel", sel, i);
        end
        @(negedge clk);
        check("full_done", frame_done, 1);
        check("full_gap1_ready", in_ready, 0);
        check("full_gap1_busy", busy, 1);
        @(negedge clk);
        check("full_done_pulse", frame_done, 0);
        check("full_gap2_ready", in_ready, 0);
        check("full_gap2_busy", busy, 1);
        @(negedge clk);
        check("full_idle_ready", in_ready, 1);
        check("full_idle_busy", busy, 0);

        // Sparse mask: channels 1, 4, 7.
        push_frame(8'hFF, 8'b1001_0010);
        send(8'hFF, 8'b1001_0010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sparse_ov", out_valid, 1);
        end
        @(negedge clk);
        check("sparse_done", frame_done, 1);

        // Hold for 3 cycles while sel = 2; data 0A gives din 0,1,0,1.
        push_frame(8'h0A, 8'h0F);
        send(8'h0A, 8'h0F);
        @(negedge clk);
        check("hold_c1_sel", sel, 0);
        cyc();
        @(negedge clk);
        check("hold_c2_sel", sel, 1);
        cyc();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_sel", sel, 2);
            check("hold_din", din, 0);
            check("hold_ov", out_valid, 0);
            cyc();
        end
        hold = 1'b0;
        @(negedge clk);
        check("hold_resume_sel", sel, 2);
        check("hold_resume_ov", out_valid, 1);
        cyc();
        @(negedge clk);
        check("hold_last_sel", sel, 3);
        cyc();
        @(negedge clk);
        check("hold_done_at_8", frame_done, 1);

        // Empty mask: frame_done the cycle after acceptance, then GAP.
        push_done();
        send(8'h5A, 8'h00);
        @(negedge clk);
        check("empty_done", frame_done, 1);
        check("empty_ov", out_valid, 0);
        check("empty_busy", busy, 1);
        check("empty_ready", in_ready, 0);

        // Abort at sel = 3; data 3C gives din 0,0,1,1 on channels 0..3.
        push_dlv(3'd0, 1'b0);
        push_dlv(3'd1, 1'b0);
        push_dlv(3'd2, 1'b1);
        push_dlv(3'd3, 1'b1);
        send(8'h3C, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc();
        end
        abort = 1'b1;
        @(negedge clk);
        check("abort_at_sel", sel, 3);
        cyc();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_sel", sel, 0);
        check("abort_din", din, 0);
        check("abort_ready", in_ready, 1);
        check("abort_no_done", frame_done, 0);

        // Abort together with an offered word: the word is dropped.
        in_data  = 8'hFF;
        in_mask  = 8'hFF;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        @(negedge clk);
        check("abort_accept_busy", busy, 0);
        check("abort_accept_ov", out_valid, 0);
        check("abort_accept_ready", in_ready, 1);

        // New word after abort.
        push_frame(8'h81, 8'h81);
        send(8'h81, 8'h81);
        repeat (3) @(negedge clk);

        // Async reset mid-SHIFT: channels 0 and 1 delivered, rest discarded.
        push_dlv(3'd0, 1'b1);
        push_dlv(3'd1, 1'b1);
        send(8'hFF, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", sel, 0);
        check("arst_din", din, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", in_ready, 0);
        check("arst_ov", out_valid, 0);
        check("arst_done", frame_done, 0);
        @(posedge clk);
        @(negedge clk);
        check("arst_held_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("arst_release_ready", in_ready, 0);
        @(negedge clk);
        check("arst_first_edge_ready", in_ready, 1);

        // Single-bit mask: one SHIFT cycle on channel 6.
        push_frame(8'h40, 8'h40);
        send(8'h40, 8'h40);
        @(negedge clk);
        check("single_sel", sel, 6);
        check("single_ov", out_valid, 1);
        @(negedge clk);
        check("single_done", frame_done, 1);

        wait_ready();
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_demux_chan_sequencer

// File: doc/demux_chan_sequencer.md
Name: demux_chan_sequencer

Overview:
- Upstream feeder for the 1-to-8 demultiplexer stage.
- Accepts an 8-bit parallel word plus an 8-bit channel-enable mask through a valid/ready handshake.
- Serialises the word one channel per cycle, driving the demux `din`/`sel` pair and visiting only enabled channels in ascending order.
- Signals frame completion and enforces an optional inter-frame gap.

Parameters:
- NCH, 8, number of demux channels; legal value 8 only.
- SEL_W, 3, select width, log2(NCH).
- GAP_CYCLES, 2, idle cycles after each frame before the next word is accepted; 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NCH  word to distribute; bit k goes to channel k.
- in_mask  input  NCH  channel enables; bit k=1 means channel k is visited.
- in_valid  input  1  word/mask present.
- in_ready  output  1  block can accept a word.
- hold  input  1  stall request from downstream; freezes delivery.
- abort  input  1  synchronous frame abort.
- sel  output  SEL_W  demux select.
- din  output  1  demux data bit.
- out_valid  output  1  current sel/din is a delivered channel.
- frame_done  output  1  one-cycle pulse after the last channel of a frame.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE.
  - sel = 0, din = 0, in_ready = 0, frame_done = 0, busy = 0.
  - Data, mask and gap counter cleared.
  - in_ready (registered) rises on the first clock edge after rst_n deasserts.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid && in_ready: latch in_data and in_mask, in_ready -> 0.
  - Mask nonzero: go to SHIFT with sel = lowest set mask bit and din = in_data[that bit].
  - Mask zero: no channel is driven; frame_done pulses on the next cycle; go to GAP, or straight to IDLE if GAP_CYCLES = 0.
- Latency: a word accepted at edge T has its first channel on sel/din during the cycle after T.
- SHIFT:
  - out_valid = (state == SHIFT) && !hold. This is the only combinational path from an input to an output.
  - hold = 1: sel, din and the mask pointer are frozen; nothing is delivered.
  - hold = 0:
    - The channel on sel is delivered.
    - At the edge, clear that mask bit and move sel/din to the next set bit above it.
    - If no bit remains: go to GAP (or IDLE if GAP_CYCLES = 0), pulse frame_done for exactly one cycle, and clear sel/din to 0.
- Frame length: a frame with N set mask bits takes exactly N unstalled SHIFT cycles. Stalled cycles add 1:1.
- GAP:
  - Counter loads GAP_CYCLES, decrements each cycle, and returns to IDLE when it reaches 1.
  - in_ready = 0 throughout.
  - hold is ignored in GAP.
- sel and din are 0 in IDLE and GAP.
- busy = 1 in SHIFT and GAP.
- abort (any state, sampled at edge):
  - Next state is IDLE, sel/din are cleared, in_ready = 1, and no frame_done is generated.
  - abort has priority over hold and over a simultaneous accept; the word offered in that cycle is not accepted.
- Mask = 8'hFF: channels 0..7 are delivered in 8 consecutive cycles.
- Single-bit mask: the frame lasts 1 SHIFT cycle.
- in_valid while in_ready = 0: ignored; the upstream source must hold it.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Decomposition:
- Shared package:
  - State encoding constants IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2.
  - NCH/SEL_W defaults.
- Sub-module lowest_set_idx, combinational: 8-bit vector in, 3-bit index plus any flag out. It is used both for the initial channel and for the next channel after clearing the current bit.

Test Plan:
- After reset release: in_data = 8'hA5, mask = 8'hFF, no hold.
  - Expected: in_ready = 1 before acceptance.
  - Expected: 8 consecutive cycles with out_valid = 1, sel = 0..7 and din = 1,0,1,0,0,1,0,1.
  - Expected: frame_done for 1 cycle, then 2 GAP cycles with in_ready = 0, then in_ready = 1.
- Sparse mask: in_data = 8'hFF, mask = 8'b1001_0010.
  - Expected: sel = 1, 4, 7 in three consecutive cycles, din = 1 each, then frame_done.
- Hold: mask = 8'h0F, hold high for 3 cycles while sel = 2.
  - Expected: sel = 2 and din stable, out_valid = 0 for those 3 cycles.
  - Expected: delivery resumes with sel = 2, then 3; total frame time 7 cycles.
- Empty mask: mask = 8'h00.
  - Expected: no out_valid; frame_done pulses the cycle after acceptance; GAP follows.
- Abort at sel = 3 of mask = 8'hFF.
  - Expected: next cycle IDLE, sel = 0, no frame_done, in_ready = 1.
  - Expected: a new word is accepted normally.
- Async reset asserted mid-SHIFT (between clock edges).
  - Expected: outputs go to reset values immediately; in_ready = 0 until the first edge after release.
